// File: rtl/regfile_pkg.sv
// Shared register-file types for the writeback path: widths, the write request
// struct and a one-hot decode helper.
package regfile_pkg;
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_W-1:0]      data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] oh;
    oh    = '0;
    oh[a] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/regfile_wb_arb_if.sv
// Writeback bus: ALU and mem producer handshakes, the register-file write port
// and the pending-write mask. slave = arbiter side, master = producers/consumer side.
interface regfile_wb_arb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                 alu_valid, alu_ready;
  logic [ADDR_W-1:0]    alu_addr;
  logic [DATA_W-1:0]    alu_data;
  logic                 mem_valid, mem_ready;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_data;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic [2**ADDR_W-1:0] busy_mask;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, wr_en, wr_addr, wr_data, busy_mask
  );
  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, wr_en, wr_addr, wr_data, busy_mask
  );
endinterface

// File: rtl/wb_fifo.sv
// Sync FIFO of writeback requests; exposes occupancy and per-slot valid/addr
// so the owner can build a scoreboard mask of queued destinations.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push_i,
  input  wb_req_t                              push_req_i,
  input  logic                                 pop_i,
  output wb_req_t                              head_o,
  output logic [$clog2(DEPTH):0]               count_o,
  output logic [DEPTH-1:0]                     ent_vld_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_addr_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t        mem_q [DEPTH];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  count_q;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= push_req_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off           = PW'(i) - rptr_q;
    assign ent_vld_o[i]  = ({1'b0, off} < count_q);
    assign ent_addr_o[i] = mem_q[i].addr;
  end
endmodule

// File: rtl/regfile_wb_arb.sv
// Register-file writeback arbiter: ALU results direct, mem results via FIFO,
// registered write port and pending-write mask. Optional counters: REGFILE_WB_STATS_EN.
module regfile_wb_arb
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = REG_W,
  parameter int ADDR_W     = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_arb_if.slave   bus
`ifdef REGFILE_WB_STATS_EN
  ,
  output logic [31:0]       wr_count,
  output logic [31:0]       x0_drop_count
`endif
);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int NREG = 2**ADDR_W;

  logic [CW-1:0]                          count;
  logic                                   full, push, pop, sel_vld;
  wb_req_t                                head, sel;
  logic [FIFO_DEPTH-1:0]                  ent_vld;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0]  ent_addr;
  logic                                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]                      wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]                      wr_data_q, wr_data_d;
  logic [NREG-1:0]                        busy_d;

  assign full          = (count == CW'(FIFO_DEPTH));
  assign bus.alu_ready = !full;
  assign bus.mem_ready = !full;
  assign push          = bus.mem_valid && !full;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_req_i ('{addr: bus.mem_addr, data: bus.mem_data}),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .ent_vld_o  (ent_vld),
    .ent_addr_o (ent_addr)
  );

  // A full FIFO forcibly drains one entry, which guarantees the ALU wins next cycle.
  always_comb begin
    pop     = 1'b0;
    sel_vld = 1'b0;
    sel     = head;
    if (full) begin
      pop     = 1'b1;
      sel_vld = 1'b1;
    end else if (bus.alu_valid) begin
      sel_vld = 1'b1;
      sel     = '{addr: bus.alu_addr, data: bus.alu_data};
    end else if (count != '0) begin
      pop     = 1'b1;
      sel_vld = 1'b1;
    end
  end

  always_comb begin
    wr_en_d   = sel_vld && (sel.addr != '0);
    wr_addr_d = sel_vld ? sel.addr : wr_addr_q;
    wr_data_d = sel_vld ? sel.data : wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  always_comb begin
    busy_d = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (ent_vld[i]) busy_d = busy_d | reg_onehot(ent_addr[i]);
    if (wr_en_q) busy_d = busy_d | reg_onehot(wr_addr_q);
    busy_d[0] = 1'b0;
  end
  assign bus.busy_mask = busy_d;

`ifdef REGFILE_WB_STATS_EN
  logic [31:0] wr_cnt_q, x0_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
      x0_cnt_q <= '0;
    end else begin
      if (wr_en_q && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (sel_vld && (sel.addr == '0) && (x0_cnt_q != '1)) x0_cnt_q <= x0_cnt_q + 1'b1;
    end
  end

  assign wr_count      = wr_cnt_q;
  assign x0_drop_count = x0_cnt_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: single producers, x0, contention/fairness,
// FIFO wrap with steady push+pop, and reset mid-stream.
module tb_regfile_wb_arb;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arb_if bus ();
`ifdef REGFILE_WB_STATS_EN
  logic [31:0] wr_count, x0_drop_count;
`endif

  regfile_wb_arb dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus)
`ifdef REGFILE_WB_STATS_EN
    ,
    .wr_count      (wr_count),
    .x0_drop_count (x0_drop_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream stimulus tables
  logic [4:0]  alu_a [16];
  logic [31:0] alu_d [16];
  logic [4:0]  mem_a [16];
  logic [31:0] mem_d [16];
  logic [4:0]  exp_a [16];
  logic [31:0] exp_d [16];
  int          n_alu, n_mem, n_exp;
  bit          crdy_en [32];
  logic        crdy    [32];
  bit          cmask_en[32];
  logic [31:0] cmask   [32];

  task automatic clr_tables();
    n_alu = 0; n_mem = 0; n_exp = 0;
    for (int i = 0; i < 32; i++) begin
      crdy_en[i] = 0; crdy[i] = 1'b0; cmask_en[i] = 0; cmask[i] = '0;
    end
  endtask

  task automatic add_alu(input logic [4:0] a, input logic [31:0] d);
    alu_a[n_alu] = a; alu_d[n_alu] = d; n_alu++;
  endtask
  task automatic add_mem(input logic [4:0] a, input logic [31:0] d);
    mem_a[n_mem] = a; mem_d[n_mem] = d; n_mem++;
  endtask
  task automatic add_exp(input logic [4:0] a, input logic [31:0] d);
    exp_a[n_exp] = a; exp_d[n_exp] = d; n_exp++;
  endtask

  task automatic run_stream(input string nm);
    int ai = 0, mi = 0, wi = 0, cyc = 0;
    bit aacc, macc;
    while ((ai < n_alu || mi < n_mem || wi < n_exp) && cyc < 40) begin
      bus.alu_valid = (ai < n_alu);
      bus.alu_addr  = alu_a[ai];
      bus.alu_data  = alu_d[ai];
      bus.mem_valid = (mi < n_mem);
      bus.mem_addr  = mem_a[mi];
      bus.mem_data  = mem_d[mi];
      @(negedge clk);
      aacc = bus.alu_valid && bus.alu_ready;
      macc = bus.mem_valid && bus.mem_ready;
      if (crdy_en[cyc]) begin
        chk({nm, "_alu_rdy"}, 64'(bus.alu_ready), 64'(crdy[cyc]));
        chk({nm, "_mem_rdy"}, 64'(bus.mem_ready), 64'(crdy[cyc]));
      end
      if (cmask_en[cyc]) chk({nm, "_mask"}, 64'(bus.busy_mask), 64'(cmask[cyc]));
      if (bus.wr_en) begin
        if (wi < n_exp) begin
          chk({nm, "_wr_addr"}, 64'(bus.wr_addr), 64'(exp_a[wi]));
          chk({nm, "_wr_data"}, 64'(bus.wr_data), 64'(exp_d[wi]));
        end else begin
          chk({nm, "_extra_wr"}, 64'd1, 64'd0);
        end
        wi++;
      end
      tick();
      if (aacc) ai++;
      if (macc) mi++;
      cyc++;
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    chk({nm, "_nwr"}, 64'(wi), 64'(n_exp));
    @(negedge clk);
    chk({nm, "_idle_we"}, 64'(bus.wr_en), 64'd0);
    chk({nm, "_idle_mask"}, 64'(bus.busy_mask), 64'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_we",   64'(bus.wr_en), 64'd0);
    chk("rst_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_data", 64'(bus.wr_data), 64'd0);
    chk("rst_mask", 64'(bus.busy_mask), 64'd0);
    chk("rst_ardy", 64'(bus.alu_ready), 64'd1);
    chk("rst_mrdy", 64'(bus.mem_ready), 64'd1);
    tick();

    // x0 destination: slot consumed, no write
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'hFF;
    @(negedge clk);
    chk("x0_ardy", 64'(bus.alu_ready), 64'd1);
    tick();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    chk("x0_we",   64'(bus.wr_en), 64'd0);
    chk("x0_mask", 64'(bus.busy_mask), 64'd0);
    chk("x0_data", 64'(bus.wr_data), 64'hFF);
`ifdef REGFILE_WB_STATS_EN
    chk("x0_drops", 64'(x0_drop_count), 64'd1);
    chk("x0_wrcnt", 64'(wr_count), 64'd0);
`endif
    tick();

    // ALU only
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("alu_ardy", 64'(bus.alu_ready), 64'd1);
    chk("alu_mask0", 64'(bus.busy_mask), 64'd0);
    tick();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    chk("alu_we",   64'(bus.wr_en), 64'd1);
    chk("alu_addr", 64'(bus.wr_addr), 64'd5);
    chk("alu_data", 64'(bus.wr_data), 64'hDEADBEEF);
    chk("alu_mask", 64'(bus.busy_mask), 64'h20);
    tick();
    @(negedge clk);
    chk("alu_we_off",  64'(bus.wr_en), 64'd0);
    chk("alu_mask_off", 64'(bus.busy_mask), 64'd0);
    tick();

    // Mem only: two-cycle latency through the FIFO
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd3; bus.mem_data = 32'h11;
    @(negedge clk);
    chk("mem_mrdy", 64'(bus.mem_ready), 64'd1);
    tick();
    bus.mem_valid = 1'b0;
    @(negedge clk);
    chk("mem_we_n1",   64'(bus.wr_en), 64'd0);
    chk("mem_mask_n1", 64'(bus.busy_mask), 64'h8);
    tick();
    @(negedge clk);
    chk("mem_we_n2",   64'(bus.wr_en), 64'd1);
    chk("mem_addr",    64'(bus.wr_addr), 64'd3);
    chk("mem_data",    64'(bus.wr_data), 64'h11);
    chk("mem_mask_n2", 64'(bus.busy_mask), 64'h8);
    tick();
    @(negedge clk);
    chk("mem_we_off",  64'(bus.wr_en), 64'd0);
    chk("mem_mask_off", 64'(bus.busy_mask), 64'd0);
`ifdef REGFILE_WB_STATS_EN
    chk("st_wrcnt", 64'(wr_count), 64'd2);
    chk("st_drops", 64'(x0_drop_count), 64'd1);
`endif
    tick();

    // Contention: A1..A6 (addr 9..14), M1..M6 (addr 17..22)
    clr_tables();
    for (int k = 0; k < 6; k++) add_alu(5'(9 + k), 32'hA001 + k);
    for (int k = 0; k < 6; k++) add_mem(5'(17 + k), 32'hB001 + k);
    add_exp(5'd9,  32'hA001); add_exp(5'd10, 32'hA002);
    add_exp(5'd11, 32'hA003); add_exp(5'd12, 32'hA004);
    add_exp(5'd17, 32'hB001); add_exp(5'd13, 32'hA005);
    add_exp(5'd18, 32'hB002); add_exp(5'd14, 32'hA006);
    add_exp(5'd19, 32'hB003); add_exp(5'd20, 32'hB004);
    add_exp(5'd21, 32'hB005); add_exp(5'd22, 32'hB006);
    for (int c = 4; c <= 9; c++) begin
      crdy_en[c] = 1;
      crdy[c]    = (c % 2 == 1);
    end
    cmask_en[4] = 1;
    cmask[4]    = 32'h001E_1000;
    run_stream("cont");

    // Wrap: X1,X2 hold off pops so FIFO sits at 2 while E0..E9 stream through
    clr_tables();
    add_alu(5'd20, 32'h5001);
    add_alu(5'd21, 32'h5002);
    for (int k = 0; k < 10; k++) add_mem(5'(k + 1), 32'hC0 + k);
    add_exp(5'd20, 32'h5001);
    add_exp(5'd21, 32'h5002);
    for (int k = 0; k < 10; k++) add_exp(5'(k + 1), 32'hC0 + k);
    cmask_en[2] = 1;
    cmask[2]    = 32'h0020_0006;
    for (int c = 3; c <= 9; c++) begin
      cmask_en[c] = 1;
      cmask[c]    = 32'h7 << (c - 2);
    end
    crdy_en[2] = 1; crdy[2] = 1'b1;
    crdy_en[9] = 1; crdy[9] = 1'b1;
    run_stream("wrap");

    // Reset mid-stream with 3 mem entries queued
    for (int k = 0; k < 3; k++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 5'(25 + k); bus.alu_data = 32'hD0 + k;
      bus.mem_valid = 1'b1; bus.mem_addr = 5'(4 + k);  bus.mem_data = 32'hE0 + k;
      tick();
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    @(negedge clk);
    chk("mid_mask_pre", 64'(bus.busy_mask), 64'h0800_0070);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_we",   64'(bus.wr_en), 64'd0);
    chk("mid_mask", 64'(bus.busy_mask), 64'd0);
    chk("mid_mrdy", 64'(bus.mem_ready), 64'd1);
`ifdef REGFILE_WB_STATS_EN
    chk("mid_wrcnt", 64'(wr_count), 64'd0);
    chk("mid_drops", 64'(x0_drop_count), 64'd0);
`endif
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      chk("mid_stale_we", 64'(bus.wr_en), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_wb_arb.md
Name: regfile_wb_arb

Overview:
- Writeback-side driver of the 32x32 register file write port.
- Merges results from two producers into the single write port (wr_en/wr_addr/wr_data):
  - ALU: single-cycle results, unbuffered.
  - Load/store unit (mem): variable-latency results, held in a small FIFO.
- Exports a pending-write mask so issue logic can scoreboard in-flight destinations.

Parameters:
- FIFO_DEPTH, 4, mem result FIFO entries; power of 2, >= 2.
- DATA_W, 32, result/register width.
- ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid.
- alu_addr  in  ADDR_W  destination register.
- alu_data  in  DATA_W  result value.
- mem_valid  in  1  mem result offered.
- mem_ready  out  1  mem result pushed into FIFO when high with mem_valid.
- mem_addr  in  ADDR_W  destination register.
- mem_data  in  DATA_W  load value.
- wr_en  out  1  register file write enable (registered).
- wr_addr  out  ADDR_W  register file write index (registered).
- wr_data  out  DATA_W  register file write data (registered).
- busy_mask  out  2**ADDR_W  bit i high = write to reg i pending in FIFO or output register.

Behaviour:
- Reset state: wr_en=0, wr_addr=0, wr_data=0, FIFO empty (count=0), busy_mask=0.
- Reset mid-operation: all pending writes are discarded; no write issues after reset.
- Handshakes:
  - alu_ready = (count != FIFO_DEPTH), combinational.
  - mem_ready = (count != FIFO_DEPTH), combinational; does not depend on a same-cycle pop.
  - A transfer occurs when valid && ready. Producers hold addr/data stable while valid && !ready.
- Per-cycle selection, in priority order:
  - count == FIFO_DEPTH: select FIFO head (pop); ALU stalled.
  - Else if alu_valid: select ALU.
  - Else if count != 0: select FIFO head (pop).
  - Else: nothing selected.
- Fairness: a forced drain leaves count = DEPTH-1, so a waiting ALU result wins the next cycle. The ALU waits at most 1 cycle.
- Output register, loaded every cycle:
  - If a selection is made: wr_addr/wr_data take the selected entry; wr_en = (selected addr != 0).
  - If no selection: wr_en=0; wr_addr/wr_data hold their values.
- x0 destination: handshake completes and the selection slot is used, but no write is issued.
- Latency:
  - ALU accepted in cycle N -> wr_en high in N+1.
  - mem pushed in cycle N -> earliest pop N+1 -> wr_en high in N+2.
- FIFO behaviour:
  - Simultaneous push and pop is allowed whenever count < DEPTH; count stays unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Mem results are written in arrival order.
- Ordering: no ordering is enforced between ALU and mem results to the same register; issue logic uses busy_mask.
- busy_mask:
  - Combinational OR of one-hot(addr) over valid FIFO entries, plus one-hot(wr_addr) when wr_en=1.
  - Bit 0 is always 0.

Optional Feature:
- Macro: REGFILE_WB_STATS_EN.
- Defined: adds two outputs, both cleared by rst:
  - wr_count [31:0]: +1 per cycle with wr_en=1; saturates at 0xFFFFFFFF.
  - x0_drop_count [31:0]: +1 per selected entry with addr 0; saturates at 0xFFFFFFFF.
- Undefined: both ports and both counters are absent.

Decomposition:
- Shared package regfile_pkg holds:
  - Constants REG_W=32, REG_ADDR_W=5, NUM_REGS=32.
  - typedef wb_req_t as a packed struct {addr, data}.
- One natural sub-module, wb_fifo: a parameterized sync FIFO of wb_req_t exposing count and per-entry valid/addr for busy_mask generation.

Test Plan:
- ALU only: alu addr=5, data=0xDEADBEEF, valid 1 cycle at N -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF at N+1; busy_mask[5]=1 at N+1 only.
- Mem only: push addr=3, data=0x11 at N -> wr_en=1, wr_addr=3 at N+2; busy_mask[3]=1 during N+1..N+2.
- Contention: ALU valid every cycle and 4 mem pushes back-to-back -> FIFO fills (mem_ready=0, alu_ready=0). Then: one mem write, then the ALU write, alternating. No write is lost and mem order is preserved.
- x0: alu addr=0 data=0xFF -> alu_ready=1, wr_en stays 0, busy_mask=0; with REGFILE_WB_STATS_EN, x0_drop_count=1 and wr_count=0.
- Simultaneous push/pop at count=2 -> count remains 2. Head/tail wrap is exercised across 10 consecutive entries, and data order matches push order.
- Reset mid-stream with 3 entries queued -> next cycle wr_en=0, busy_mask=0, mem_ready=1; no stale write appears afterward.
